// File: rtl/dmem_bus_if_pkg.sv
// Shared types for the data-side Wishbone bus interface.
package dmem_bus_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/dmem_bus_if_if.sv
// Wishbone-classic signal bundle between the MEM-stage bus master and memory.
interface dmem_bus_if_if
  import dmem_bus_if_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_W-1:0]     adr;
  logic [DATA_W/8-1:0]   sel;
  logic [DATA_W-1:0]     dat_m2s;
  logic [DATA_W-1:0]     dat_s2m;
  logic                  ack;

  modport master (
    output cyc, stb, we, adr, sel, dat_m2s,
    input  dat_s2m, ack
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m2s,
    output dat_s2m, ack
  );

endinterface

// File: rtl/dmem_bus_if.sv
// MEM-stage data bus master: one Wishbone-classic access per request, with
// pipeline stall, completion hold under external stall, flush abort and timeout.
module dmem_bus_if
  import dmem_bus_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stall_req_o,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic                bus_err_o,
  dmem_bus_if_if.master       wb
);

  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     adr_q, adr_d;
  logic [DATA_W/8-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]     dat_q, dat_d;
  logic [DATA_W-1:0]     rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  timeout_hit;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^cpu_addr_i[1:0];
  assign timeout_hit      = (cnt_q == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      rd_buf_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      sel_q    <= sel_d;
      dat_q    <= dat_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rd_buf_d    = rd_buf_q;
    cnt_d       = cnt_q;
    err_d       = 1'b0;
    stall_req_o = 1'b0;
    cpu_data_o  = '0;

    case (state_q)
      IDLE: begin
        stall_req_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          adr_d   = {cpu_addr_i[ADDR_W-1:2], 2'b00};
          sel_d   = cpu_sel_i;
          we_d    = cpu_we_i;
          dat_d   = cpu_data_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Ack outranks flush so a committed store is never reported as aborted.
        if (wb.ack) begin
          cpu_data_o = we_q ? '0 : wb.dat_s2m;
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          sel_d      = '0;
          rd_buf_d   = wb.dat_s2m;
          state_d    = (stall_i && !flush_i) ? HOLD : IDLE;
        end else if (flush_i) begin
          stall_req_o = 1'b1;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          state_d     = IDLE;
        end else if (timeout_hit) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_req_o = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        cpu_data_o = rd_buf_q;
        if (!stall_i || flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb.cyc     = cyc_q;
  assign wb.stb     = cyc_q;
  assign wb.we      = we_q;
  assign wb.adr     = adr_q;
  assign wb.sel     = sel_q;
  assign wb.dat_m2s = dat_q;
  assign bus_err_o  = err_q;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Self-checking bench for dmem_bus_if: directed vector table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_dmem_bus_if;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_ce, cpu_we, stall, flush;
  logic [AW-1:0] cpu_addr;
  logic [SW-1:0] cpu_sel;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          stall_req, bus_err;

  dmem_bus_if_if #(.ADDR_W(AW), .DATA_W(DW)) wb ();

  dmem_bus_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_ce_i    (cpu_ce),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_sel_i   (cpu_sel),
    .cpu_data_i  (cpu_wdata),
    .cpu_data_o  (cpu_rdata),
    .stall_req_o (stall_req),
    .stall_i     (stall),
    .flush_i     (flush),
    .bus_err_o   (bus_err),
    .wb          (wb)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wd, input logic ack,
                       input logic [31:0] rd, input logic st, input logic fl);
    cpu_ce     = ce;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_sel    = sel;
    cpu_wdata  = wd;
    wb.ack     = ack;
    wb.dat_s2m = rd;
    stall      = st;
    flush      = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic        ce, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        e_stall;
    logic [31:0] e_data;
    logic        e_cyc, e_we;
    logic [31:0] e_adr;
    logic [3:0]  e_sel;
    logic [31:0] e_dato;
  } vec_t;

  vec_t vt[9];

  function automatic vec_t mk(input logic ce, input logic we, input logic [31:0] addr,
                              input logic [3:0] sel, input logic [31:0] wdat, input logic ack,
                              input logic [31:0] rdat, input logic es, input logic [31:0] ed,
                              input logic ec, input logic ew, input logic [31:0] ea,
                              input logic [3:0] esl, input logic [31:0] edo);
    vec_t v;
    v.ce = ce; v.we = we; v.addr = addr; v.sel = sel; v.wdat = wdat; v.ack = ack; v.rdat = rdat;
    v.e_stall = es; v.e_data = ed; v.e_cyc = ec; v.e_we = ew; v.e_adr = ea; v.e_sel = esl;
    v.e_dato = edo;
    return v;
  endfunction

  // Transaction-level reference: pending request, wait count, held load data.
  bit          m_act, m_hold, m_err;
  int          m_wait;
  logic [31:0] m_hold_d, m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we;

  initial begin
    logic        e_stall;
    logic [31:0] e_data;

    idle_in();
    #2;
    chk("rst_cyc", wb.cyc, 1'b0);
    chk("rst_stb", wb.stb, 1'b0);
    chk("rst_we", wb.we, 1'b0);
    chk("rst_adr", wb.adr, 32'h0);
    chk("rst_sel", wb.sel, 4'h0);
    chk("rst_dato", wb.dat_m2s, 32'h0);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_stall", stall_req, 1'b0);
    chk("rst_data", cpu_rdata, 32'h0);
    next_cycle();
    reset = 1'b1;

    // Load with two wait states, zero-wait store, stray ack while idle.
    vt[0] = mk(1'b1, 1'b0, 32'h1006, 4'b0010, 32'h0BADF00D, 1'b0, 32'h0,
               1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    vt[1] = mk(1'b1, 1'b0, 32'h1006, 4'b0010, 32'h0BADF00D, 1'b0, 32'h0,
               1'b1, 32'h0, 1'b1, 1'b0, 32'h1004, 4'b0010, 32'h0BADF00D);
    vt[2] = mk(1'b1, 1'b0, 32'h1006, 4'b0010, 32'h0BADF00D, 1'b0, 32'h0,
               1'b1, 32'h0, 1'b1, 1'b0, 32'h1004, 4'b0010, 32'h0BADF00D);
    vt[3] = mk(1'b1, 1'b0, 32'h1006, 4'b0010, 32'h0BADF00D, 1'b1, 32'hAABBCCDD,
               1'b0, 32'hAABBCCDD, 1'b1, 1'b0, 32'h1004, 4'b0010, 32'h0BADF00D);
    vt[4] = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
               1'b0, 32'h0, 1'b0, 1'b0, 32'h1004, 4'h0, 32'h0BADF00D);
    vt[5] = mk(1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0, 32'h0,
               1'b1, 32'h0, 1'b0, 1'b0, 32'h1004, 4'h0, 32'h0BADF00D);
    vt[6] = mk(1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b1, 32'hFFFFFFFF,
               1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678);
    vt[7] = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0,
               1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 4'h0, 32'h12345678);
    vt[8] = mk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h55,
               1'b0, 32'h0, 1'b0, 1'b0, 32'h20, 4'h0, 32'h12345678);

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].ce, vt[i].we, vt[i].addr, vt[i].sel, vt[i].wdat, vt[i].ack, vt[i].rdat,
            1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), stall_req, vt[i].e_stall);
      chk($sformatf("vec%0d_data", i), cpu_rdata, vt[i].e_data);
      chk($sformatf("vec%0d_cyc", i), wb.cyc, vt[i].e_cyc);
      chk($sformatf("vec%0d_stb", i), wb.stb, vt[i].e_cyc);
      chk($sformatf("vec%0d_we", i), wb.we, vt[i].e_we);
      chk($sformatf("vec%0d_adr", i), wb.adr, vt[i].e_adr);
      chk($sformatf("vec%0d_sel", i), wb.sel, vt[i].e_sel);
      chk($sformatf("vec%0d_dato", i), wb.dat_m2s, vt[i].e_dato);
      chk($sformatf("vec%0d_err", i), bus_err, 1'b0);
      next_cycle();
    end

    // Completion while the pipeline is stalled elsewhere: data held, no reissue.
    drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); chk("hold_req_stall", stall_req, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_ack_stall", stall_req, 1'b0);
    chk("hold_ack_data", cpu_rdata, 32'hDEADBEEF);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, 32'h0, (i < 4) ? 1'b1 : 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("hold%0d_data", i), cpu_rdata, 32'hDEADBEEF);
      chk($sformatf("hold%0d_stall", i), stall_req, 1'b0);
      chk($sformatf("hold%0d_cyc", i), wb.cyc, 1'b0);
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      idle_in();
      @(negedge clk);
      chk($sformatf("hold_after%0d_cyc", i), wb.cyc, 1'b0);
      chk($sformatf("hold_after%0d_data", i), cpu_rdata, 32'h0);
      next_cycle();
    end

    // Flush in the second BUSY cycle aborts silently; later ack ignored.
    drive(1'b1, 1'b0, 32'h80, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk); chk("fl_busy1_cyc", wb.cyc, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h80, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk); chk("fl_busy2_cyc", wb.cyc, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h77, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl_cyc", wb.cyc, 1'b0);
    chk("fl_stb", wb.stb, 1'b0);
    chk("fl_stall", stall_req, 1'b0);
    chk("fl_data", cpu_rdata, 32'h0);
    chk("fl_err", bus_err, 1'b0);
    next_cycle();
    idle_in();
    @(negedge clk);
    chk("fl_late_cyc", wb.cyc, 1'b0);
    chk("fl_late_err", bus_err, 1'b0);
    next_cycle();

    // Timeout: cyc held TMO+1 cycles, then a one-cycle error pulse.
    drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk); chk("to_req_stall", stall_req, 1'b1);
    next_cycle();
    for (int i = 0; i <= int'(TMO); i++) begin
      @(negedge clk);
      chk($sformatf("to%0d_cyc", i), wb.cyc, 1'b1);
      chk($sformatf("to%0d_stall", i), stall_req, (i < int'(TMO)) ? 1'b1 : 1'b0);
      chk($sformatf("to%0d_data", i), cpu_rdata, 32'h0);
      chk($sformatf("to%0d_err", i), bus_err, 1'b0);
      next_cycle();
    end
    idle_in();
    @(negedge clk);
    chk("to_end_cyc", wb.cyc, 1'b0);
    chk("to_end_err", bus_err, 1'b1);
    chk("to_end_stall", stall_req, 1'b0);
    next_cycle();
    @(negedge clk); chk("to_err_clear", bus_err, 1'b0);
    next_cycle();

    // Asynchronous reset between clock edges mid-store.
    drive(1'b1, 1'b1, 32'h200, 4'hF, 32'hCAFE0001, 1'b0, 32'h0, 1'b0, 1'b0);
    next_cycle();
    @(negedge clk); chk("ar_busy_we", wb.we, 1'b1);
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    chk("ar_cyc", wb.cyc, 1'b0);
    chk("ar_stb", wb.stb, 1'b0);
    chk("ar_we", wb.we, 1'b0);
    chk("ar_err", bus_err, 1'b0);
    chk("ar_idle_stall", stall_req, 1'b1);
    idle_in();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("ar_rel_cyc", wb.cyc, 1'b0);
    chk("ar_rel_stall", stall_req, 1'b0);
    next_cycle();

    // Randomized run from a fresh reset against the reference model.
    reset = 1'b0;
    #2;
    reset = 1'b1;
    m_act = 0; m_hold = 0; m_err = 0; m_wait = 0;
    m_hold_d = '0; m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0;
    next_cycle();
    for (int n = 0; n < 600; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom),
            4'($urandom_range(0, 15)), 32'($urandom), ($urandom_range(0, 9) < 3),
            32'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      @(negedge clk);
      e_stall = 1'b0;
      e_data  = '0;
      if (m_act) begin
        if (wb.ack) e_data = m_we ? 32'h0 : wb.dat_s2m;
        else if (flush || m_wait != int'(TMO)) e_stall = 1'b1;
      end else if (m_hold) begin
        e_data = m_hold_d;
      end else begin
        e_stall = cpu_ce & ~flush;
      end
      chk("rnd_stall", stall_req, e_stall);
      chk("rnd_data", cpu_rdata, e_data);
      chk("rnd_cyc", wb.cyc, m_act);
      chk("rnd_stb", wb.stb, m_act);
      chk("rnd_adr", wb.adr, m_adr);
      chk("rnd_dato", wb.dat_m2s, m_dat);
      chk("rnd_err", bus_err, m_err);
      if (m_act) begin
        chk("rnd_we", wb.we, m_we);
        chk("rnd_sel", wb.sel, m_sel);
      end
      m_err = 0;
      if (m_act) begin
        if (wb.ack) begin
          m_act    = 0;
          m_hold   = stall & ~flush;
          m_hold_d = wb.dat_s2m;
        end else if (flush) begin
          m_act = 0;
        end else if (m_wait == int'(TMO)) begin
          m_act = 0;
          m_err = 1;
        end else begin
          m_wait++;
        end
      end else if (m_hold) begin
        if (!stall || flush) m_hold = 0;
      end else if (cpu_ce && !flush) begin
        m_act  = 1;
        m_wait = 0;
        m_adr  = {cpu_addr[31:2], 2'b00};
        m_sel  = cpu_sel;
        m_we   = cpu_we;
        m_dat  = cpu_wdata;
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
